// File: rtl/reg_bank_sched.sv
// reg_bank_sched: round-robin scheduler sharing one bank of WIDTH-bit entries
// between NREQ requesters. One registered grant per cycle; the bank commits the
// granted write/clear/preset on the edge that ends the grant cycle. Read port
// is combinational and shows the pre-commit value during a grant cycle.
// Optional burst locking is compiled in with `define REG_BANK_SCHED_LOCK_EN.
module reg_bank_sched #(
  parameter int unsigned      NREQ      = 4,
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      AW        = 2,
  parameter logic [WIDTH-1:0] INIT      = '0,
  parameter int unsigned      BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [AW*NREQ-1:0]    addr,
  input  logic [WIDTH*NREQ-1:0] wdata,
  input  logic [NREQ-1:0]       lock,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  err,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_LOCKED} state_t;

  state_t            r_state, w_state_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt, w_elig;
  logic [PW-1:0]     r_rr_ptr, w_gidx, w_cand;
  logic              w_found;
  logic              r_busy, r_err, w_bad;
  logic [1:0]        r_cop, w_op_sel;
  logic [AW-1:0]     r_caddr, w_addr_sel;
  logic [WIDTH-1:0]  r_cwdata, w_wdata_sel;
  logic [WIDTH-1:0]  r_bank [DEPTH];
  logic              w_lk_cont;

`ifdef REG_BANK_SCHED_LOCK_EN
  localparam int unsigned BW = $clog2(BURST_MAX + 1);
  logic [PW-1:0] r_lk;
  logic [BW-1:0] r_burst, w_burst_nxt;

  // Locked owner keeps the bank while it keeps both req and lock asserted
  assign w_lk_cont = (r_state == S_LOCKED) && req[r_lk] && lock[r_lk];
`else
  logic w_unused_lock;
  assign w_lk_cont     = 1'b0;
  assign w_unused_lock = (^lock) ^ (r_state == S_LOCKED) ^ (BURST_MAX == 0);
`endif

  // Arbitration and next-state: round-robin over req masked by the current grant
  always_comb begin
    w_elig      = req & ~r_gnt;
    w_found     = 1'b0;
    w_gidx      = r_rr_ptr;
    w_cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = PW'((32'(r_rr_ptr) + k) % NREQ);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
`ifdef REG_BANK_SCHED_LOCK_EN
    // A continuing burst overrides round-robin and bypasses the mask
    if (w_lk_cont) begin
      w_found = 1'b1;
      w_gidx  = r_lk;
    end
`endif
    w_gnt_nxt = '0;
    if (w_found) w_gnt_nxt[w_gidx] = 1'b1;
    w_state_nxt = w_found ? S_GRANT : S_IDLE;
`ifdef REG_BANK_SCHED_LOCK_EN
    w_burst_nxt = r_burst;
    if (w_lk_cont) begin
      // Last allowed grant drops back to GRANT so the normal mask blocks i next cycle
      w_burst_nxt = BW'(32'(r_burst) + 1);
      w_state_nxt = ((32'(r_burst) + 1) < BURST_MAX) ? S_LOCKED : S_GRANT;
    end else if (w_found && lock[w_gidx] && (BURST_MAX > 1)) begin
      w_burst_nxt = BW'(1);
      w_state_nxt = S_LOCKED;
    end
`endif
  end

  // Select the granted requester's transaction fields for capture
  always_comb begin
    w_op_sel    = '0;
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (PW'(i) == w_gidx) begin
        w_op_sel    = op[2*i +: 2];
        w_addr_sel  = addr[AW*i +: AW];
        w_wdata_sel = wdata[WIDTH*i +: WIDTH];
      end
    end
  end

  assign w_bad = (r_cop == 2'b11) || (32'(r_caddr) >= DEPTH);

  // Control registers: state, grant, pointer, captured transaction, flags
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= PW'(NREQ - 1);
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_cop    <= '0;
      r_caddr  <= '0;
      r_cwdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= (|w_gnt_nxt) || (w_state_nxt == S_LOCKED);
      r_err   <= (|r_gnt) && w_bad;
      if (w_found) begin
        r_rr_ptr <= w_gidx;
        r_cop    <= w_op_sel;
        r_caddr  <= w_addr_sel;
        r_cwdata <= w_wdata_sel;
      end
    end
  end

`ifdef REG_BANK_SCHED_LOCK_EN
  // Burst owner and grant count
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_lk    <= '0;
      r_burst <= '0;
    end else begin
      if (w_found) r_lk <= w_gidx;
      r_burst <= w_burst_nxt;
    end
  end
`endif

  // Bank commit at the end of the grant cycle; reset drops any pending commit
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_bank[i] <= INIT;
    end else if ((|r_gnt) && !w_bad) begin
      case (r_cop)
        2'b00:   r_bank[r_caddr] <= r_cwdata;
        2'b01:   r_bank[r_caddr] <= '0;
        2'b10:   r_bank[r_caddr] <= '1;
        default: ;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign err     = r_err;
  assign rd_data = (32'(rd_addr) < DEPTH) ? r_bank[rd_addr] : '0;

endmodule

// File: tb/tb_reg_bank_sched.sv
// Bench for reg_bank_sched: two instances (DEPTH=4 and DEPTH=3) share stimulus.
// Expected per-cycle grants/flags are queued when stimulus is set up and popped
// as the design produces each grant cycle.
module tb_reg_bank_sched;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  req, lock;
  logic [7:0]  op, addr;
  logic [31:0] wdata;
  logic [1:0]  rd_addr;
  logic [3:0]  gnt, gnt3;
  logic        busy, busy3, err, err3;
  logic [7:0]  rd_data, rd_data3;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       lock;
  } txn_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic       err;
    logic       err3;
    logic       rdchk;
    logic [7:0] rd;
    logic [7:0] rd3;
  } exp_t;

  txn_t        txs [4][8];
  int unsigned ntx [4];
  int unsigned pos [4];
  exp_t        sb_q [$];

  always #5 clk = ~clk;

  reg_bank_sched #(.NREQ(4), .WIDTH(8), .DEPTH(4), .AW(2), .INIT(8'h00), .BURST_MAX(4)) u_dut (
    .clk(clk), .clr(clr), .req(req), .op(op), .addr(addr), .wdata(wdata), .lock(lock),
    .gnt(gnt), .busy(busy), .err(err), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  reg_bank_sched #(.NREQ(4), .WIDTH(8), .DEPTH(3), .AW(2), .INIT(8'h00), .BURST_MAX(4)) u_dut3 (
    .clk(clk), .clr(clr), .req(req), .op(op), .addr(addr), .wdata(wdata), .lock(lock),
    .gnt(gnt3), .busy(busy3), .err(err3), .rd_addr(rd_addr), .rd_data(rd_data3)
  );

  function automatic void push(logic [3:0] g, logic e, logic e3, logic rc, logic [7:0] r, logic [7:0] r3);
    exp_t x;
    x.gnt = g; x.err = e; x.err3 = e3; x.rdchk = rc; x.rd = r; x.rd3 = r3;
    sb_q.push_back(x);
  endfunction

  function automatic void add_tx(int unsigned i, logic [1:0] o, logic [1:0] a, logic [7:0] d, logic l);
    txn_t t;
    t.op = o; t.addr = a; t.wdata = d; t.lock = l;
    txs[i][ntx[i]] = t;
    ntx[i]++;
  endfunction

  task automatic clear_all();
    for (int unsigned i = 0; i < 4; i++) begin
      ntx[i] = 0;
      pos[i] = 0;
    end
    req = '0; lock = '0; op = '0; addr = '0; wdata = '0;
  endtask

  task automatic present(int unsigned i);
    txn_t t;
    if (pos[i] < ntx[i]) begin
      t = txs[i][pos[i]];
      req[i]           = 1'b1;
      lock[i]          = t.lock;
      op[2*i +: 2]     = t.op;
      addr[2*i +: 2]   = t.addr;
      wdata[8*i +: 8]  = t.wdata;
    end else begin
      req[i]  = 1'b0;
      lock[i] = 1'b0;
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_chk++;
      if (gnt !== e.gnt) begin n_fail++; $display("FAIL gnt cyc=%0d got %b expected %b", cyc, gnt, e.gnt); end
      n_chk++;
      if (gnt3 !== e.gnt) begin n_fail++; $display("FAIL gnt3 cyc=%0d got %b expected %b", cyc, gnt3, e.gnt); end
      n_chk++;
      if (busy !== (|e.gnt)) begin n_fail++; $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, |e.gnt); end
      n_chk++;
      if (busy3 !== (|e.gnt)) begin n_fail++; $display("FAIL busy3 cyc=%0d got %b expected %b", cyc, busy3, |e.gnt); end
      n_chk++;
      if (err !== e.err) begin n_fail++; $display("FAIL err cyc=%0d got %b expected %b", cyc, err, e.err); end
      n_chk++;
      if (err3 !== e.err3) begin n_fail++; $display("FAIL err3 cyc=%0d got %b expected %b", cyc, err3, e.err3); end
      if (e.rdchk) begin
        n_chk++;
        if (rd_data !== e.rd) begin n_fail++; $display("FAIL rd cyc=%0d got %h expected %h", cyc, rd_data, e.rd); end
        n_chk++;
        if (rd_data3 !== e.rd3) begin n_fail++; $display("FAIL rd3 cyc=%0d got %h expected %h", cyc, rd_data3, e.rd3); end
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (gnt[i] === 1'b1) begin
        pos[i]++;
        present(i);
      end
    end
  endtask

  task automatic run(int unsigned n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    clear_all();
    rd_addr = 2'd1;
    add_tx(0, 2'b00, 2'd1, 8'h99, 1'b0);
    push(4'b0001, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    push(4'b0000, 1'b0, 1'b0, 1'b1, 8'h99, 8'h99);
    present(0);
    run(2);
    #2 clr = 1'b0;
    #1;
    n_chk++;
    if (gnt !== 4'b0000 || gnt3 !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b/%b expected 0000", gnt, gnt3); end
    n_chk++;
    if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags got busy=%b err=%b expected 0 0", busy, err); end
    for (int unsigned a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      n_chk++;
      if (rd_data !== 8'h00 || rd_data3 !== 8'h00) begin
        n_fail++; $display("FAIL reset_rd addr=%0d got %h/%h expected 00", a, rd_data, rd_data3);
      end
    end
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_fill();
    logic [7:0] ex [4];
    logic [7:0] ex3 [4];
    clear_all();
    for (int unsigned i = 0; i < 4; i++) add_tx(i, 2'b00, 2'(i), 8'hA0 + 8'(i), 1'b0);
    push(4'b0001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0100, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b1000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0000, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int unsigned i = 0; i < 4; i++) present(i);
    run(5);
    ex[0] = 8'hA0; ex[1] = 8'hA1; ex[2] = 8'hA2; ex[3] = 8'hA3;
    ex3[0] = 8'hA0; ex3[1] = 8'hA1; ex3[2] = 8'hA2; ex3[3] = 8'h00;
    for (int unsigned a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      n_chk++;
      if (rd_data !== ex[a]) begin n_fail++; $display("FAIL fill_rd addr=%0d got %h expected %h", a, rd_data, ex[a]); end
      n_chk++;
      if (rd_data3 !== ex3[a]) begin n_fail++; $display("FAIL fill_rd3 addr=%0d got %h expected %h", a, rd_data3, ex3[a]); end
    end
    clear_all();
  endtask

  task automatic test_back_to_back();
    clear_all();
    for (int unsigned k = 0; k < 4; k++) begin
      add_tx(0, 2'b00, 2'd0, 8'h10 + 8'(k), 1'b0);
      add_tx(2, 2'b00, 2'd1, 8'h20 + 8'(k), 1'b0);
      push(4'b0001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      push(4'b0100, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    push(4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    present(0);
    present(2);
    run(9);
    rd_addr = 2'd0;
    #1;
    n_chk++;
    if (rd_data !== 8'h13 || rd_data3 !== 8'h13) begin n_fail++; $display("FAIL b2b_rd0 got %h/%h expected 13", rd_data, rd_data3); end
    rd_addr = 2'd1;
    #1;
    n_chk++;
    if (rd_data !== 8'h23 || rd_data3 !== 8'h23) begin n_fail++; $display("FAIL b2b_rd1 got %h/%h expected 23", rd_data, rd_data3); end
    clear_all();
  endtask

  task automatic test_ops_err();
    clear_all();
    rd_addr = 2'd2;
    add_tx(1, 2'b10, 2'd2, 8'h00, 1'b0);
    add_tx(1, 2'b01, 2'd2, 8'h00, 1'b0);
    add_tx(1, 2'b11, 2'd2, 8'h77, 1'b0);
    add_tx(1, 2'b00, 2'd3, 8'h3C, 1'b0);
    push(4'b0010, 1'b0, 1'b0, 1'b1, 8'hA2, 8'hA2);
    push(4'b0000, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF);
    push(4'b0010, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF);
    push(4'b0000, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    push(4'b0010, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    push(4'b0000, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    push(4'b0010, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    push(4'b0000, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    present(1);
    run(8);
    rd_addr = 2'd3;
    #1;
    n_chk++;
    if (rd_data !== 8'h3C) begin n_fail++; $display("FAIL ops_rd3_depth4 got %h expected 3c", rd_data); end
    n_chk++;
    if (rd_data3 !== 8'h00) begin n_fail++; $display("FAIL ops_rd3_depth3 got %h expected 00", rd_data3); end
    clear_all();
  endtask

  task automatic test_reset_in_grant();
    clear_all();
    add_tx(3, 2'b00, 2'd1, 8'h5A, 1'b0);
    present(3);
    @(posedge clk);
    #1;
    cyc++;
    n_chk++;
    if (gnt !== 4'b1000) begin n_fail++; $display("FAIL rig_gnt got %b expected 1000", gnt); end
    #2 clr = 1'b0;
    #1;
    n_chk++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL rig_async got gnt=%b busy=%b err=%b expected 0000 0 0", gnt, busy, err);
    end
    clear_all();
    @(posedge clk);
    #1;
    n_chk++;
    if (gnt !== 4'b0000 || gnt3 !== 4'b0000) begin n_fail++; $display("FAIL rig_held got %b/%b expected 0000", gnt, gnt3); end
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rd_addr = 2'd1;
    #1;
    n_chk++;
    if (rd_data !== 8'h00 || rd_data3 !== 8'h00) begin n_fail++; $display("FAIL rig_rd got %h/%h expected 00", rd_data, rd_data3); end
    n_chk++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rig_gnt_after got %b expected 0000", gnt); end
  endtask

  task automatic test_lock();
    clear_all();
    for (int unsigned k = 0; k < 6; k++) add_tx(1, 2'b00, 2'd0, 8'hB0 + 8'(k), 1'b1);
    for (int unsigned k = 0; k < 2; k++) add_tx(0, 2'b00, 2'd1, 8'hC0 + 8'(k), 1'b0);
`ifdef REG_BANK_SCHED_LOCK_EN
    push(4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
`else
    push(4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    push(4'b0001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int unsigned k = 0; k < 4; k++) begin
      push(4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      push(4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    end
`endif
    present(1);
    step();
    present(0);
    while (sb_q.size() != 0) step();
    rd_addr = 2'd0;
    #1;
    n_chk++;
    if (rd_data !== 8'hB5 || rd_data3 !== 8'hB5) begin n_fail++; $display("FAIL lock_rd0 got %h/%h expected b5", rd_data, rd_data3); end
    rd_addr = 2'd1;
    #1;
    n_chk++;
    if (rd_data !== 8'hC1 || rd_data3 !== 8'hC1) begin n_fail++; $display("FAIL lock_rd1 got %h/%h expected c1", rd_data, rd_data3); end
    clear_all();
  endtask

  initial begin
    clr = 1'b0;
    rd_addr = '0;
    clear_all();
    repeat (3) @(negedge clk);
    clr = 1'b1;
    test_reset();
    test_fill();
    test_back_to_back();
    test_ops_err();
    test_reset_in_grant();
    test_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
